// File: rtl/first_nios2_system_pio_poller.sv
// first_nios2_system_pio_poller: periodic Avalon-MM poller of an input PIO with edge capture and irq.
// Define PIO_POLLER_DEBOUNCE_EN to accept a value only after two identical consecutive captures.
module first_nios2_system_pio_poller #(
    parameter int DATA_W = 8,
    parameter int PERIOD_W = 16,
    parameter int RESET_PERIOD = 1000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  s_address,
    input  logic        s_write,
    input  logic [31:0] s_writedata,
    input  logic        s_read,
    output logic [31:0] s_readdata,
    output logic [1:0]  m_address,
    output logic        m_read,
    input  logic [31:0] m_readdata,
    output logic        irq
);
    typedef enum logic [1:0] {IDLE, READ, CAPTURE} state_t;
    state_t state, state_n;
    logic [DATA_W-1:0] sample, edges, mask, rd, set_bits, clr_bits;
    logic [PERIOD_W-1:0] period, counter;
    logic enable, irq_en, valid, capture, accept, ctrl_wr, clr_valid, unused;
    assign m_address = 2'd0;
    assign rd = m_readdata[DATA_W-1:0];
    assign capture = state == CAPTURE;
    assign ctrl_wr = s_write && s_address == 2'd1;
    assign clr_valid = (state == IDLE && !enable) || (ctrl_wr && !s_writedata[0]);
    assign clr_bits = (s_write && s_address == 2'd3) ? s_writedata[DATA_W-1:0] : '0;
    assign set_bits = (capture && accept && valid) ? (rd ^ sample) & mask : '0;
    assign unused = ^{s_read, s_writedata, m_readdata};
    always_comb begin
        state_n = (state == IDLE) ? ((enable && counter == '0) ? READ : IDLE) :
                  (state == READ) ? CAPTURE : IDLE;
        m_read = state == READ;
    end
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) state <= IDLE;
        else state <= state_n;
`ifdef PIO_POLLER_DEBOUNCE_EN
    logic [DATA_W-1:0] cand;
    logic cand_valid;
    assign accept = cand_valid && cand == rd;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            cand <= '0;
            cand_valid <= 1'b0;
        end else if (capture) begin
            cand <= rd;
            cand_valid <= 1'b1;
        end else if (clr_valid) begin
            cand_valid <= 1'b0;
        end
`else
    assign accept = 1'b1;
`endif
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            s_readdata <= '0;
            irq <= 1'b0;
            sample <= '0;
            edges <= '0;
            valid <= 1'b0;
            enable <= 1'b0;
            irq_en <= 1'b0;
            mask <= '1;
            period <= PERIOD_W'(RESET_PERIOD);
            counter <= '0;
        end else begin
            s_readdata <= (s_address == 2'd0) ? 32'(sample) :
                          (s_address == 2'd1) ? 32'({mask, 6'b0, irq_en, enable}) :
                          (s_address == 2'd2) ? 32'(period) : 32'(edges);
            irq <= irq_en && |edges;
            // a capture setting a bit overrides a same-cycle write-1-clear of it
            edges <= (edges & ~clr_bits) | set_bits;
            if (ctrl_wr) begin
                enable <= s_writedata[0];
                irq_en <= s_writedata[1];
                mask <= s_writedata[8 +: DATA_W];
            end
            if (s_write && s_address == 2'd2) period <= s_writedata[PERIOD_W-1:0];
            if (capture && accept) begin
                sample <= rd;
                valid <= 1'b1;
            end else if (clr_valid) begin
                valid <= 1'b0;
            end
            if (capture) counter <= period;
            else if (state == IDLE) counter <= (!enable || counter == '0) ? '0 : counter - 1'b1;
        end
endmodule

// File: tb/tb_first_nios2_system_pio_poller.sv
// tb_first_nios2_system_pio_poller: directed checks of registers, poll timing, edge capture and irq.
module tb_first_nios2_system_pio_poller;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic [1:0] s_address = 2'd0;
    logic s_write = 1'b0;
    logic [31:0] s_writedata = '0;
    logic s_read = 1'b0;
    logic [31:0] s_readdata;
    logic [1:0] m_address;
    logic m_read;
    logic [31:0] m_readdata = '0;
    logic irq;
    logic [7:0] in_port = 8'h00;
    logic [7:0] seq [6] = '{8'h00, 8'h00, 8'h3C, 8'h00, 8'h3C, 8'h3C};
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int last = -1;
    int intv = 0;
    int npulse = 0;

    first_nios2_system_pio_poller dut (
        .clk(clk), .reset_n(reset_n),
        .s_address(s_address), .s_write(s_write), .s_writedata(s_writedata),
        .s_read(s_read), .s_readdata(s_readdata),
        .m_address(m_address), .m_read(m_read), .m_readdata(m_readdata),
        .irq(irq)
    );

    always #5 clk = ~clk;

    // PIO model: registered readdata
    always @(posedge clk) m_readdata <= {24'b0, in_port};

    always @(negedge clk) begin
        cyc++;
        if (m_read) begin
            if (last >= 0) intv = cyc - last;
            last = cyc;
            npulse++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        s_address = a;
        s_write = 1'b1;
        s_writedata = d;
        @(negedge clk);
        s_write = 1'b0;
    endtask

    task automatic rd_reg(input string tag, input logic [1:0] a, input logic [31:0] exp);
        @(negedge clk);
        s_address = a;
        s_read = 1'b1;
        @(negedge clk);
        s_read = 1'b0;
        check(tag, s_readdata, exp);
    endtask

    task automatic wait_rd();
        bit found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            found = m_read;
        end
        if (!found) check("read_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_irq", {31'b0, irq}, 32'd0);
        check("rst_mread", {31'b0, m_read}, 32'd0);
        check("rst_maddr", {30'b0, m_address}, 32'd0);
        check("rst_rdata", s_readdata, 32'd0);
        reset_n = 1'b1;
        rd_reg("rst_sample", 2'd0, 32'h0);
        rd_reg("rst_ctrl", 2'd1, 32'h0000FF00);
        rd_reg("rst_period", 2'd2, 32'd1000);
        rd_reg("rst_edge", 2'd3, 32'h0);
        repeat (5) @(negedge clk);
        check("no_poll_disabled", npulse, 32'd0);

        wr(2'd2, 32'd5);
        in_port = 8'hA5;
        wr(2'd1, 32'h3);
        repeat (40) @(negedge clk);
        check("interval_p5", intv, 32'd8);
        rd_reg("p5_sample", 2'd0, 32'hA5);
        rd_reg("p5_edge", 2'd3, 32'h0);
        rd_reg("p5_ctrl", 2'd1, 32'h3);
        check("p5_irq", {31'b0, irq}, 32'd0);

        wr(2'd1, 32'h0);
        wr(2'd2, 32'd0);
        in_port = 8'h00;
        wr(2'd1, 32'hFF03);
        repeat (15) @(negedge clk);
        check("interval_p0", intv, 32'd3);
        rd_reg("reen_sample", 2'd0, 32'h00);
        rd_reg("reen_no_edge", 2'd3, 32'h00);
        in_port = 8'h81;
        repeat (10) @(negedge clk);
        rd_reg("edge_81", 2'd3, 32'h81);
        check("irq_set", {31'b0, irq}, 32'd1);
        wr(2'd3, 32'h01);
        rd_reg("edge_w1c_bit0", 2'd3, 32'h80);
        check("irq_still", {31'b0, irq}, 32'd1);
        wr(2'd3, 32'h80);
        repeat (3) @(negedge clk);
        check("irq_clear", {31'b0, irq}, 32'd0);
        rd_reg("edge_clear", 2'd3, 32'h00);

        wr(2'd1, 32'h0);
        in_port = 8'h00;
        wr(2'd1, 32'h0F03);
        repeat (10) @(negedge clk);
        wr(2'd3, 32'hFF);
        in_port = 8'hFF;
        repeat (10) @(negedge clk);
        rd_reg("mask_edge", 2'd3, 32'h0F);
        check("mask_irq", {31'b0, irq}, 32'd1);
        wr(2'd1, 32'h0003);
        rd_reg("mask_change_keeps", 2'd3, 32'h0F);

        wr(2'd1, 32'h0);
        wr(2'd3, 32'hFF);
        in_port = 8'h00;
        wr(2'd1, 32'h0103);
        repeat (10) @(negedge clk);
        wait_rd();
        in_port = 8'h01;
        @(negedge clk);
        s_address = 2'd3;
        s_write = 1'b1;
        s_writedata = 32'h01;
        @(negedge clk);
        s_write = 1'b0;
        rd_reg("set_wins", 2'd3, 32'h01);
        wr(2'd3, 32'h01);
        rd_reg("w1c_no_capture_edge", 2'd3, 32'h00);

        wr(2'd1, 32'h0);
        wr(2'd2, 32'd20);
        wr(2'd3, 32'hFF);
        wr(2'd1, 32'hFF01);
        for (int i = 0; i < 6; i++) begin
            wait_rd();
            in_port = seq[i];
            if (i == 2 || i == 5) begin
                repeat (2) @(negedge clk);
`ifdef PIO_POLLER_DEBOUNCE_EN
                rd_reg($sformatf("seq_edge_%0d", i), 2'd3, i == 2 ? 32'h00 : 32'h3C);
                rd_reg($sformatf("seq_sample_%0d", i), 2'd0, i == 2 ? 32'h00 : 32'h3C);
`else
                rd_reg($sformatf("seq_edge_%0d", i), 2'd3, 32'h3C);
                rd_reg($sformatf("seq_sample_%0d", i), 2'd0, 32'h3C);
`endif
            end
        end

        wr(2'd1, 32'hFF03);
        wait_rd();
        #1 reset_n = 1'b0;
        #1 check("async_rst_mread", {31'b0, m_read}, 32'd0);
        check("async_rst_irq", {31'b0, irq}, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        rd_reg("post_rst_ctrl", 2'd1, 32'h0000FF00);
        rd_reg("post_rst_edge", 2'd3, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/first_nios2_system_pio_poller.md
Name: first_nios2_system_pio_poller

Overview:
- Avalon-MM master/slave controller that sequences periodic polling of an 8-bit input PIO's data register (PIO address 0; PIO readdata is registered, so read latency is 1).
- Keeps the last sampled value and records per-bit changes in an edge-capture register.
- Raises an interrupt to the Nios II, so software does not spin-read the PIO.
- Sits between the CPU data master (slave side) and the PIO s1 slave (master side).

Parameters:
- DATA_W, 8, width of PIO data / sample / edge registers
- PERIOD_W, 16, width of poll period counter
- RESET_PERIOD, 1000, period register value after reset

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- s_address  in  2  config slave register select
- s_write  in  1  config slave write strobe
- s_writedata  in  32  config slave write data
- s_read  in  1  config slave read strobe
- s_readdata  out  32  config slave read data, registered, latency 1
- m_address  out  2  PIO address, constant 0
- m_read  out  1  PIO read strobe
- m_readdata  in  32  PIO read data, valid the cycle after m_read
- irq  out  1  level interrupt

Behaviour:
- Reset (async, reset_n=0):
  - s_readdata=0, m_read=0, irq=0, m_address=0.
  - sample=0, edge=0, valid=0.
  - ctrl: enable=0, irq_en=0, mask=all 1s.
  - period=RESET_PERIOD, counter=0.
  - State=IDLE.
- Slave map; bits not listed read 0 and ignore writes:
  - 0: SAMPLE [DATA_W-1:0], read-only.
  - 1: CTRL. bit0 enable, bit1 irq_en, bits[8+DATA_W-1:8] mask.
  - 2: PERIOD [PERIOD_W-1:0].
  - 3: EDGE [DATA_W-1:0]. Write-1-to-clear per bit.
- s_readdata is updated every cycle with the addressed register, regardless of s_read. Value is visible the cycle after the address is presented.
- FSM:
  - IDLE: if enable=0, hold counter=0. If enable=1 and counter==0, go to READ. Otherwise decrement counter.
  - READ: m_read=1 for exactly one cycle, then go to CAPTURE.
  - CAPTURE: take new=m_readdata[DATA_W-1:0].
    - If valid=1: edge |= (new ^ sample) & mask.
    - Then sample<=new, valid<=1, counter<=period, go to IDLE.
- Poll interval is period+3 cycles from READ to READ: 1 READ + 1 CAPTURE + (period+1) IDLE. period=0 gives back-to-back polling every 3 cycles.
- First capture after reset, or after enable goes 0->1, updates sample only. No edges are recorded. Clearing enable resets valid=0.
- Writing enable=0 while in READ or CAPTURE lets the transaction complete; the capture is recorded. The FSM then stays in IDLE.
- Writing PERIOD takes effect at the next reload; the running count is not disturbed.
- Simultaneous CAPTURE edge-set and EDGE write-1-clear on the same bit: set wins.
- Edge bits masked off are never set. Changing the mask does not clear existing edge bits.
- irq = irq_en & (|edge), registered with 1-cycle latency from the edge/ctrl update.
- Mid-operation reset returns all state to reset values immediately; m_read drops asynchronously.

Optional Feature:
- Macro: PIO_POLLER_DEBOUNCE_EN.
- With the macro defined:
  - A candidate register holds the last raw capture.
  - A new value is accepted into sample/edge only when two consecutive captures are identical.
  - A mismatching capture replaces the candidate only.
  - The first accepted value after enable sets valid without recording edges.
- Without the macro: every capture is accepted directly as described above.

Test Plan:
- Reset then read all four registers -> SAMPLE=0, CTRL=0x0000FF00, PERIOD=1000, EDGE=0, irq=0, m_read never asserted.
- PERIOD=5, CTRL=0x3 (mask=0), in_port=0xA5 -> m_read pulses every 8 cycles, SAMPLE=0xA5, EDGE stays 0, irq=0.
- CTRL=0xFF03, PERIOD=0, in_port 0x00->0x81 after first capture -> EDGE=0x81, irq=1 one cycle after CAPTURE. Write EDGE=0x01 -> EDGE=0x80, irq stays 1. Write EDGE=0x80 -> irq=0.
- Mask=0x0F, in_port 0x00->0xFF -> EDGE=0x0F only.
- Input toggles bit0 every poll; write EDGE=0x01 in the same cycle as CAPTURE -> bit0 stays set.
- Debounce build: in_port 0x00,0x00,0x3C,0x00,0x3C,0x3C over successive polls -> sample becomes 0x3C only after the sixth poll, EDGE=0x3C. Non-debounce build with the same stimulus -> EDGE=0x3C after the third poll.
